// File: rtl/xmt_controller.sv
// UART transmit controller: one-deep holding buffer feeding an 11-bit frame
// (start, 8 data LSB first, parity, stop). Define XMT_ODD_PARITY_EN for odd parity.
module xmt_controller (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       WR,
    input  logic [7:0] Din,
    output logic       TxD,
    output logic       TxRDY,
    output logic       Idle,
    output logic       Start,
    output logic       Shift,
    output logic       Parity,
    output logic       Stop
);

    // One-hot encoding so each state flag is a single register bit.
    localparam logic [4:0] XMT_IDLE   = 5'b00001;
    localparam logic [4:0] XMT_START  = 5'b00010;
    localparam logic [4:0] XMT_SHIFT  = 5'b00100;
    localparam logic [4:0] XMT_PARITY = 5'b01000;
    localparam logic [4:0] XMT_STOP   = 5'b10000;

    logic [4:0] state_q, state_d;
    logic [7:0] buf_q,   buf_d;
    logic       full_q,  full_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       par_q,   par_d;
    logic       load;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        buf_d   = buf_q;
        full_d  = full_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        load    = 1'b0;

        // A write is only taken while the buffer is empty; a transfer needs it full,
        // so the two can never collide on the same edge.
        if (WR && !full_q) begin
            buf_d  = Din;
            full_d = 1'b1;
        end

        case (state_q)
            XMT_IDLE: begin
                if (full_q) begin
                    state_d = XMT_START;
                    load    = 1'b1;
                end
            end
            XMT_START: state_d = XMT_SHIFT;
            XMT_SHIFT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = XMT_PARITY;
                end else begin
                    shreg_d = shreg_q >> 1;
                end
            end
            XMT_PARITY: state_d = XMT_STOP;
            XMT_STOP: begin
                if (full_q) begin
                    state_d = XMT_START;
                    load    = 1'b1;
                end else begin
                    state_d = XMT_IDLE;
                end
            end
            default: state_d = XMT_IDLE;
        endcase

        if (load) begin
            shreg_d = buf_q;
            cnt_d   = 3'd0;
            full_d  = 1'b0;
`ifdef XMT_ODD_PARITY_EN
            par_d   = ~^buf_q;
`else
            par_d   = ^buf_q;
`endif
        end
    end

    // NOTE: every register, including the data buffers, is cleared by reset so an abort leaves nothing behind.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= XMT_IDLE;
            buf_q   <= 8'h00;
            full_q  <= 1'b0;
            shreg_q <= 8'h00;
            cnt_q   <= 3'd0;
            par_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    // Line value decoded purely from registers; WR/Din never reach TxD directly.
    always_comb begin
        TxD = 1'b1;
        case (state_q)
            XMT_START:  TxD = 1'b0;
            XMT_SHIFT:  TxD = shreg_q[0];
            XMT_PARITY: TxD = par_q;
            default:    TxD = 1'b1;
        endcase
    end

    assign TxRDY  = ~full_q;
    assign Idle   = state_q[0];
    assign Start  = state_q[1];
    assign Shift  = state_q[2];
    assign Parity = state_q[3];
    assign Stop   = state_q[4];

endmodule

// File: tb/tb_xmt_controller.sv
// Directed self-checking bench for xmt_controller; frames checked bit by bit
// against hand-built expected vectors (start, data LSB first, parity, stop).
module tb_xmt_controller;

`ifdef XMT_ODD_PARITY_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic       Clock;
    logic       Reset;
    logic       WR;
    logic [7:0] Din;
    logic       TxD;
    logic       TxRDY;
    logic       Idle;
    logic       Start;
    logic       Shift;
    logic       Parity;
    logic       Stop;

    int checks = 0;
    int errors = 0;

    xmt_controller dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .WR     (WR),
        .Din    (Din),
        .TxD    (TxD),
        .TxRDY  (TxRDY),
        .Idle   (Idle),
        .Start  (Start),
        .Shift  (Shift),
        .Parity (Parity),
        .Stop   (Stop)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Flags packed as {Stop, Parity, Shift, Start, Idle}.
    function automatic logic [4:0] frame_flags(input int i);
        if (i == 0)      return 5'b00010;
        else if (i <= 8) return 5'b00100;
        else if (i == 9) return 5'b01000;
        else             return 5'b10000;
    endfunction

    task automatic test_reset;
        Reset = 1'b1;
        WR    = 1'b0;
        Din   = 8'h00;
        repeat (2) @(negedge Clock);
        checks++;
        if ({TxD, TxRDY, Stop, Parity, Shift, Start, Idle} !== 7'b1100001) begin
            errors++;
            $display("FAIL reset_held: got %b want 1100001", {TxD, TxRDY, Stop, Parity, Shift, Start, Idle});
        end
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            checks++;
            if ({TxD, TxRDY, Stop, Parity, Shift, Start, Idle} !== 7'b1100001) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b want 1100001", i, {TxD, TxRDY, Stop, Parity, Shift, Start, Idle});
            end
        end
    endtask

    // Single frame after a write in idle; second_wr optionally attempts a write
    // while the buffer is still full (must be ignored).
    task automatic run_single_frame(input string name, input logic [7:0] b,
                                    input logic [10:0] exp, input bit second_wr);
        @(negedge Clock);
        Din = b;
        WR  = 1'b1;
        @(negedge Clock);                 // after edge k
        checks++;
        if ({TxRDY, Idle, TxD} !== 3'b011) begin
            errors++;
            $display("FAIL %s after_write: TxRDY/Idle/TxD got %b want 011", name, {TxRDY, Idle, TxD});
        end
        if (second_wr) begin
            Din = 8'hFF;
            WR  = 1'b1;
        end else begin
            WR  = 1'b0;
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge Clock);             // after edge k+1+i
            WR = 1'b0;
            checks++;
            if (TxD !== exp[i]) begin
                errors++;
                $display("FAIL %s txd bit %0d: got %b want %b", name, i, TxD, exp[i]);
            end
            checks++;
            if ({Stop, Parity, Shift, Start, Idle} !== frame_flags(i)) begin
                errors++;
                $display("FAIL %s flags bit %0d: got %b want %b", name, i, {Stop, Parity, Shift, Start, Idle}, frame_flags(i));
            end
            checks++;
            if (TxRDY !== 1'b1) begin
                errors++;
                $display("FAIL %s txrdy bit %0d: got %b want 1", name, i, TxRDY);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);             // after edge k+12, k+13
            checks++;
            if ({TxD, TxRDY, Idle} !== 3'b111) begin
                errors++;
                $display("FAIL %s back_to_idle %0d: TxD/TxRDY/Idle got %b want 111", name, i, {TxD, TxRDY, Idle});
            end
        end
    endtask

    task automatic test_frame_a5;
        run_single_frame("frame_a5", 8'hA5, {1'b1, 1'b0 ^ ODD, 8'hA5, 1'b0}, 1'b0);
    endtask

    task automatic test_ignored_write;
        run_single_frame("ignored_wr", 8'h3C, {1'b1, 1'b0 ^ ODD, 8'h3C, 1'b0}, 1'b1);
    endtask

    task automatic test_zero_byte;
        run_single_frame("zero_byte", 8'h00, {1'b1, 1'b0 ^ ODD, 8'h00, 1'b0}, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [21:0] exp;
        exp = {1'b1, 1'b1 ^ ODD, 8'h80, 1'b0, 1'b1, 1'b1 ^ ODD, 8'h01, 1'b0};
        @(negedge Clock);
        Din = 8'h01;
        WR  = 1'b1;
        @(negedge Clock);                 // after edge k
        WR  = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge Clock);             // after edge k+1+i
            WR = 1'b0;
            checks++;
            if (TxD !== exp[i]) begin
                errors++;
                $display("FAIL b2b txd bit %0d: got %b want %b", i, TxD, exp[i]);
            end
            checks++;
            if ({Stop, Parity, Shift, Start, Idle} !== frame_flags(i % 11)) begin
                errors++;
                $display("FAIL b2b flags bit %0d: got %b want %b", i, {Stop, Parity, Shift, Start, Idle}, frame_flags(i % 11));
            end
            // Buffer holds 8'h80 from edge k+2 until the transfer at k+12.
            checks++;
            if (TxRDY !== !(i >= 1 && i <= 10)) begin
                errors++;
                $display("FAIL b2b txrdy bit %0d: got %b want %b", i, TxRDY, !(i >= 1 && i <= 10));
            end
            if (i == 0) begin
                Din = 8'h80;
                WR  = 1'b1;
            end
        end
        @(negedge Clock);
        checks++;
        if ({TxD, TxRDY, Idle} !== 3'b111) begin
            errors++;
            $display("FAIL b2b back_to_idle: TxD/TxRDY/Idle got %b want 111", {TxD, TxRDY, Idle});
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge Clock);
        Din = 8'hF0;
        WR  = 1'b1;
        @(negedge Clock);                 // after edge k
        WR  = 1'b0;
        @(negedge Clock);                 // after k+1: start, buffer empty again
        Din = 8'h55;
        WR  = 1'b1;
        @(negedge Clock);                 // after k+2: 8'h55 buffered
        WR  = 1'b0;
        checks++;
        if (TxRDY !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset buffered: TxRDY got %b want 0", TxRDY);
        end
        repeat (4) @(negedge Clock);      // after k+6: data bit 4
        checks++;
        if ({Shift, TxD} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset bit4: Shift/TxD got %b want 11", {Shift, TxD});
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({TxD, TxRDY, Stop, Parity, Shift, Start, Idle} !== 7'b1100001) begin
            errors++;
            $display("FAIL mid_reset async: got %b want 1100001", {TxD, TxRDY, Stop, Parity, Shift, Start, Idle});
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clock);
            checks++;
            if ({TxD, TxRDY, Idle} !== 3'b111) begin
                errors++;
                $display("FAIL mid_reset residual cycle %0d: TxD/TxRDY/Idle got %b want 111", i, {TxD, TxRDY, Idle});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_ignored_write();
        test_reset_mid_frame();
        test_zero_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
